// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: sequential instruction fetch from a registered ROM into a 2-entry FIFO with redirect and halt.
module instr_fetch_ctrl #(
  parameter logic [7:0] START_ADR = 8'h00,
  parameter logic [7:0] LAST_ADR  = 8'h48
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  adr,
  input  logic [31:0] rom_dout,
  output logic [31:0] instr,
  output logic [7:0]  instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [7:0]  redirect_pc,
  output logic        halted
);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, HALTED} state_t;
  state_t state_q, state_d;
  logic [7:0] fetch_pc_q, fetch_pc_d, inf_pc_q, inf_pc_d;
  logic inflight_q, inflight_d;
  logic [1:0] cnt_q, cnt_d, cnt_pop;
  logic [1:0][31:0] w_q, w_d;
  logic [1:0][7:0] p_q, p_d;
  logic pop, issue;
  assign adr = fetch_pc_q;
  assign instr = w_q[0];
  assign instr_pc = p_q[0];
  assign instr_valid = cnt_q != 2'd0;
  assign halted = state_q == HALTED;
  assign pop = instr_valid & instr_ready;
  assign cnt_pop = cnt_q - {1'b0, pop};
  // issue only if the slot freed by this cycle's pop leaves room for the response
  assign issue = state_q == FETCH && !redirect && fetch_pc_q <= LAST_ADR &&
                 (cnt_pop + {1'b0, inflight_q}) < 2'd2;
  always_comb begin
    state_d = state_q;
    fetch_pc_d = issue ? fetch_pc_q + 8'd4 : fetch_pc_q;
    inflight_d = issue;
    inf_pc_d = issue ? fetch_pc_q : inf_pc_q;
    cnt_d = cnt_pop + {1'b0, inflight_q};
    w_d[0] = pop ? w_q[1] : w_q[0];
    p_d[0] = pop ? p_q[1] : p_q[0];
    w_d[1] = w_q[1];
    p_d[1] = p_q[1];
    if (inflight_q && cnt_pop == 2'd0) begin
      w_d[0] = rom_dout;
      p_d[0] = inf_pc_q;
    end else if (inflight_q) begin
      w_d[1] = rom_dout;
      p_d[1] = inf_pc_q;
    end
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        fetch_pc_d = START_ADR;
      end
      FETCH: if (fetch_pc_q > LAST_ADR) state_d = DRAIN;
      DRAIN: if (cnt_q == 2'd0 && !inflight_q) state_d = HALTED;
      default: ;
    endcase
    if (redirect) begin
      state_d = FETCH;
      fetch_pc_d = {redirect_pc[7:2], 2'b00};
      cnt_d = 2'd0;
      inflight_d = 1'b0;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      fetch_pc_q <= 8'h00;
      inf_pc_q <= 8'h00;
      inflight_q <= 1'b0;
      cnt_q <= 2'd0;
      w_q <= '0;
      p_q <= '0;
    end else begin
      state_q <= state_d;
      fetch_pc_q <= fetch_pc_d;
      inf_pc_q <= inf_pc_d;
      inflight_q <= inflight_d;
      cnt_q <= cnt_d;
      w_q <= w_d;
      p_q <= p_d;
    end
  end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed checks of fetch, stall, redirect, halt and reset behaviour.
module tb_instr_fetch_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b0, start = 1'b0, instr_ready = 1'b0, redirect = 1'b0;
  logic [7:0] redirect_pc = 8'h00, adr, instr_pc;
  logic [31:0] rom_dout = 32'h0, instr;
  logic instr_valid, halted;
  int n_chk = 0, n_fail = 0;
  instr_fetch_ctrl dut (
    .clock(clock), .reset(reset), .start(start), .adr(adr), .rom_dout(rom_dout),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
  );
  always #5 clock = ~clock;
  function automatic logic [31:0] rom_word(input logic [7:0] a);
    case (a)
      8'h00: return 32'h00450693;
      8'h04: return 32'h00100713;
      8'h08: return 32'h00b76463;
      8'h0c: return 32'h00008067;
      8'h10: return 32'h0006a803;
      8'h1c: return 32'hffc62883;
      8'h48: return 32'hfc1ff06f;
      default: return 32'hc0de0000 | {24'h0, a};
    endcase
  endfunction
  always @(posedge clock) rom_dout <= rom_word(adr);
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic exp_instr(input string tag, input logic [7:0] pc);
    chk({tag, "_valid"}, {31'h0, instr_valid}, 32'h1);
    chk({tag, "_pc"}, {24'h0, instr_pc}, {24'h0, pc});
    chk({tag, "_word"}, instr, rom_word(pc));
  endtask
  task automatic tick;
    @(negedge clock);
  endtask
  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_adr", {24'h0, adr}, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", {24'h0, instr_pc}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    tick;
    reset = 1'b0;
    tick;
    start = 1'b1;
    instr_ready = 1'b1;
    tick;
    start = 1'b0;
    chk("first_lat0", {31'h0, instr_valid}, 32'h0);
    tick;
    chk("first_lat1", {31'h0, instr_valid}, 32'h0);
    tick;
    exp_instr("pc00", 8'h00);
    tick;
    exp_instr("pc04", 8'h04);
    tick;
    exp_instr("pc08", 8'h08);
    instr_ready = 1'b0;
    repeat (3) begin
      tick;
      exp_instr("pc08_hold", 8'h08);
    end
    instr_ready = 1'b1;
    tick;
    exp_instr("pc0c", 8'h0c);
    tick;
    exp_instr("pc10", 8'h10);
    instr_ready = 1'b0;
    tick;
    redirect = 1'b1;
    redirect_pc = 8'h1e;
    tick;
    redirect = 1'b0;
    chk("redir_flush", {31'h0, instr_valid}, 32'h0);
    chk("redir_adr", {24'h0, adr}, 32'h1c);
    tick;
    chk("redir_lat", {31'h0, instr_valid}, 32'h0);
    tick;
    exp_instr("pc1c", 8'h1c);
    instr_ready = 1'b1;
    for (int a = 8'h20; a <= 8'h48; a += 4) begin
      tick;
      exp_instr("run", 8'(a));
    end
    tick;
    chk("end_valid", {31'h0, instr_valid}, 32'h0);
    chk("drain_halted", {31'h0, halted}, 32'h0);
    tick;
    chk("halted", {31'h0, halted}, 32'h1);
    redirect = 1'b1;
    redirect_pc = 8'h10;
    tick;
    redirect = 1'b0;
    chk("unhalt", {31'h0, halted}, 32'h0);
    chk("unhalt_adr", {24'h0, adr}, 32'h10);
    tick;
    tick;
    exp_instr("after_halt", 8'h10);
    instr_ready = 1'b0;
    tick;
    tick;
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("mid_rst_instr", instr, 32'h0);
    chk("mid_rst_pc", {24'h0, instr_pc}, 32'h0);
    chk("mid_rst_adr", {24'h0, adr}, 32'h0);
    chk("mid_rst_halted", {31'h0, halted}, 32'h0);
    tick;
    reset = 1'b0;
    instr_ready = 1'b1;
    repeat (3) begin
      tick;
      chk("post_rst_idle", {31'h0, instr_valid}, 32'h0);
    end
    start = 1'b1;
    redirect = 1'b1;
    redirect_pc = 8'h40;
    tick;
    start = 1'b0;
    redirect = 1'b0;
    chk("redir_start_adr", {24'h0, adr}, 32'h40);
    tick;
    tick;
    exp_instr("redir_start", 8'h40);
    tick;
    exp_instr("redir_start_next", 8'h44);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 SHALL have parameter START_ADR, default 8'h00: first fetch address after start.
REQ-002 SHALL have parameter LAST_ADR, default 8'h48: highest valid word address in program ROM.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port start, input, 1: one-cycle pulse; begins fetching from IDLE.
REQ-006 SHALL have port adr, output, 8: byte address to program ROM; always equals fetch_pc register.
REQ-007 SHALL have port rom_dout, input, 32: ROM data, registered, valid the cycle after adr is presented.
REQ-008 SHALL have port instr, output, 32: instruction word to decode.
REQ-009 SHALL have port instr_pc, output, 8: address of instr.
REQ-010 SHALL have port instr_valid, output, 1: instr/instr_pc valid.
REQ-011 SHALL have port instr_ready, input, 1: decode accepts; transfer = instr_valid & instr_ready.
REQ-012 SHALL have port redirect, input, 1: branch/jump taken; one-cycle pulse.
REQ-013 SHALL have port redirect_pc, input, 8: redirect target byte address.
REQ-014 SHALL have port halted, output, 1: fetch stopped, pipeline drained.

Function
REQ-015 SHALL implement states IDLE, FETCH, DRAIN, HALTED.
REQ-016 SHALL hold a 2-entry instruction FIFO (word + pc), occupancy count 0..2, plus an inflight flag marking a ROM read whose data arrives next cycle.
REQ-017 SHALL drive instr/instr_pc/instr_valid from the FIFO head; instr_valid = (count != 0).
REQ-018 SHALL issue in FETCH when (count + inflight - pop) < 2, pop = transfer this cycle, and no redirect; issue sets inflight for next cycle, tags it with fetch_pc, and advances fetch_pc by 4.
REQ-019 SHALL, when inflight is set, push rom_dout with its tagged pc into the FIFO on that edge; push and pop in the same cycle keep count unchanged.
REQ-020 SHALL sustain one instruction per cycle with instr_ready held high; first instr_valid two cycles after start is sampled.
REQ-021 SHALL hold instr/instr_pc stable while instr_valid & !instr_ready.
REQ-022 SHALL, in FETCH, when fetch_pc > LAST_ADR, not issue and go to DRAIN.
REQ-023 SHALL, in DRAIN, go to HALTED when count == 0 and inflight == 0; halted = 1 only in HALTED.
REQ-024 SHALL, in IDLE, on start, set fetch_pc = START_ADR and go to FETCH; start ignored in other states.
REQ-025 SHALL, on redirect in any state, flush FIFO (count = 0), discard the in-flight response, set fetch_pc = {redirect_pc[7:2], 2'b00}, go to FETCH; instr_valid is 0 the following cycle.
REQ-026 SHALL give redirect priority over start, issue, push and pop in the same cycle; a transfer in the redirect cycle still counts as accepted.
REQ-027 SHALL wrap fetch_pc modulo 256 (8'hFC + 4 = 8'h00); with LAST_ADR < 8'hFC the halt rule fires first.

Reset
REQ-028 SHALL, on reset assertion, immediately set state = IDLE, fetch_pc = 8'h00 (adr = 8'h00), count = 0, inflight = 0, instr = 0, instr_pc = 0, instr_valid = 0, halted = 0.
REQ-029 SHALL, on reset mid-operation, drop all buffered and in-flight instructions; no output until a new start.

Verification
REQ-030 SHALL cover: start, instr_ready = 1, ROM model loaded with program -> instr_valid two cycles after start; pc 0x00 = 0x00450693, then pc 0x04 = 0x00100713, one per cycle.
REQ-031 SHALL cover: instr_ready low 3 cycles at pc 0x08 -> instr = 0x00b76463 held; then pc 0x0c = 0x00008067 follows, no loss or duplicate.
REQ-032 SHALL cover: redirect with redirect_pc = 0x1e while FIFO holds 2 entries -> next valid pc 0x1c = 0xffc62883, no stale words.
REQ-033 SHALL cover: free run to end -> pc 0x48 = 0xfc1ff06f delivered last, then halted = 1; redirect to 0x10 -> 0x0006a803 delivered, halted = 0.
REQ-034 SHALL cover: reset asserted mid-stream, ready = 0 -> outputs zero asynchronously; no instr_valid until next start.
REQ-035 SHALL cover: redirect and start asserted together in IDLE -> fetch begins at redirect_pc, not START_ADR.
